line_merge_buffer: RTL and testbench

Single-entry write-combining buffer between the CPU store path and the line-granular memory port. It accumulates byte-enabled word stores into one cache line and tracks a per-byte valid mask. On eviction it performs a read-modify-write: it fetches the line from memory and merges it byte-by-byte under the mask, so stored bytes win and the other bytes come from memory. It then writes the full line back. It generalises the fixed 16-byte per-byte merge mux to any line and word width, and adds accumulation, eviction sequencing and a memory handshake.

---
 rtl/line_merge_buffer_if.sv | 42 ++++
 rtl/line_merge_buffer.sv | 130 +++++++++++++
 tb/tb_line_merge_buffer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_merge_buffer_if.sv
// Store-side and memory-side bus bundle for line_merge_buffer.
// slave  : the buffer (accepts stores, issues line reads/writes).
// master : the environment (CPU store path plus the line memory).
// Signals: in_valid/in_ready/in_line_addr/in_offset/in_data/in_be, flush, idle,
//          mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_resp.
interface line_merge_buffer_if #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned ADDR_W     = 12
);
  localparam int unsigned WORDS  = LINE_BYTES / WORD_BYTES;
  localparam int unsigned OFF_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned LINE_W = 8 * LINE_BYTES;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_line_addr;
  logic [OFF_W-1:0]      in_offset;
  logic [WORD_W-1:0]     in_data;
  logic [WORD_BYTES-1:0] in_be;
  logic                  flush;
  logic                  idle;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  in_valid, in_line_addr, in_offset, in_data, in_be, flush,
           mem_rdata, mem_resp,
    output in_ready, idle, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_line_addr, in_offset, in_data, in_be, flush,
           mem_rdata, mem_resp,
    input  in_ready, idle, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/line_merge_buffer.sv
// Single-entry write-combining buffer. Byte-enabled word stores to one line are
// merged into a line register with a per-byte valid mask. Eviction (flush or a
// store to another line) reads the line from memory unless every byte is
// already valid, merges memory bytes under the mask, then writes the line back.
// Ports: clk, reset_n (async, active low), bus (line_merge_buffer_if.slave).
module line_merge_buffer #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned ADDR_W     = 12
) (
  input logic                  clk,
  input logic                  reset_n,
  line_merge_buffer_if.slave   bus
);
  localparam int unsigned WORDS  = LINE_BYTES / WORD_BYTES;
  localparam int unsigned OFF_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned LINE_W = 8 * LINE_BYTES;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [LINE_BYTES-1:0] mask_q, mask_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [ADDR_W-1:0]     line_addr_q, line_addr_d;
  logic                  idle_q, idle_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  hit_c;
  logic                  in_ready_c;
  logic                  store_en;
  logic                  evict;

  assign hit_c = (bus.in_line_addr == line_addr_q);

  // A miss store in HOLD is stalled until the held line has been evicted.
  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      S_EMPTY: in_ready_c = 1'b1;
      S_HOLD:  in_ready_c = !(bus.in_valid && !hit_c);
      default: in_ready_c = 1'b0;
    endcase
  end

  // Next state, line/mask update and registered memory-request outputs.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    line_d      = line_q;
    line_addr_d = line_addr_q;
    store_en    = 1'b0;
    evict       = 1'b0;

    case (state_q)
      S_EMPTY: begin
        if (bus.in_valid) begin
          line_addr_d = bus.in_line_addr;
          store_en    = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.in_valid && hit_c) store_en = 1'b1;
        if (bus.flush || (bus.in_valid && !hit_c)) evict = 1'b1;
      end
      S_READ: begin
        if (bus.mem_resp) begin
          for (int i = 0; i < LINE_BYTES; i++) begin
            if (!mask_q[i]) line_d[i*8 +: 8] = bus.mem_rdata[i*8 +: 8];
          end
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_resp) begin
          mask_d  = '0;
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Little-endian placement of the store word into the line.
    if (store_en) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if ((bus.in_offset == OFF_W'(i / WORD_BYTES)) && bus.in_be[i % WORD_BYTES]) begin
          line_d[i*8 +: 8] = bus.in_data[(i % WORD_BYTES)*8 +: 8];
          mask_d[i]        = 1'b1;
        end
      end
    end

    // Full mask (including a store merged this cycle) skips the read.
    if (evict) state_d = (&mask_d) ? S_WRITE : S_READ;

    idle_d      = (state_d == S_EMPTY);
    mem_read_d  = (state_d == S_READ);
    mem_write_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      mask_q      <= '0;
      line_q      <= '0;
      line_addr_q <= '0;
      idle_q      <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      line_q      <= line_d;
      line_addr_q <= line_addr_d;
      idle_q      <= idle_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.idle      = idle_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = line_addr_q;
  assign bus.mem_wdata = line_q;
endmodule

// File: tb/tb_line_merge_buffer.sv
// Bench for line_merge_buffer: byte-array buffer model, memory responder,
// per-cycle output compare and directed scenarios with literal line checks.
module tb_line_merge_buffer;
  localparam int unsigned LB = 16;
  localparam int unsigned WB = 2;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  line_merge_buffer_if #(.LINE_BYTES(LB), .WORD_BYTES(WB), .ADDR_W(AW)) bus ();

  line_merge_buffer #(.LINE_BYTES(LB), .WORD_BYTES(WB), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Buffer model: contents, validity, and eviction phase (read then write).
  logic [7:0]    m_line [LB];
  bit            m_mask [LB];
  bit            m_valid, m_evict, m_wphase, saw_read;
  logic [AW-1:0] m_addr;
  logic [AW-1:0]  wr_addr_q [$];
  logic [127:0]   wr_data_q [$];
  bit             wr_read_q [$];

  function automatic logic [127:0] pack_line();
    logic [127:0] r;
    for (int i = 0; i < LB; i++) r[i*8 +: 8] = m_line[i];
    return r;
  endfunction

  function automatic bit mask_full();
    bit f = 1'b1;
    for (int i = 0; i < LB; i++) f &= m_mask[i];
    return f;
  endfunction

  initial begin
    bit hit, was_valid, trig;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_valid = 0; m_evict = 0; m_wphase = 0; saw_read = 0; m_addr = '0;
        for (int i = 0; i < LB; i++) begin m_line[i] = 8'h00; m_mask[i] = 0; end
      end else if (m_evict) begin
        if (bus.mem_read) saw_read = 1;
        if (bus.mem_resp) begin
          if (!m_wphase) begin
            for (int i = 0; i < LB; i++)
              if (!m_mask[i]) m_line[i] = bus.mem_rdata[i*8 +: 8];
            m_wphase = 1;
          end else begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            wr_read_q.push_back(saw_read);
            m_valid = 0; m_evict = 0; saw_read = 0;
            for (int i = 0; i < LB; i++) m_mask[i] = 0;
          end
        end
      end else begin
        was_valid = m_valid;
        hit  = was_valid && (bus.in_line_addr == m_addr);
        trig = was_valid && (bus.flush || (bus.in_valid && !hit));
        if (bus.in_valid && (!was_valid || hit)) begin
          if (!was_valid) m_addr = bus.in_line_addr;
          m_valid = 1;
          for (int k = 0; k < WB; k++) begin
            if (bus.in_be[k]) begin
              m_line[int'(bus.in_offset)*WB + k] = bus.in_data[k*8 +: 8];
              m_mask[int'(bus.in_offset)*WB + k] = 1;
            end
          end
        end
        if (trig) begin
          m_evict  = 1;
          m_wphase = mask_full();
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    bit exp_ready;
    forever begin
      @(negedge clk);
      exp_ready = !m_evict && !(m_valid && bus.in_valid && (bus.in_line_addr != m_addr));
      check("idle", bus.idle, !m_valid);
      check("in_ready", bus.in_ready, exp_ready);
      check("mem_read", bus.mem_read, m_evict && !m_wphase);
      check("mem_write", bus.mem_write, m_evict && m_wphase);
      if (m_evict) check("mem_addr", bus.mem_addr, m_addr);
      if (m_evict && m_wphase) check("mem_wdata", bus.mem_wdata, pack_line());
    end
  end

  // Memory responder: completes each request after two request cycles.
  bit         resp_en = 1'b1;
  logic [7:0] mem_fill = 8'h00;
  int         lat_cnt = 0;
  initial begin
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_resp) bus.mem_resp = 1'b0;
      else if (resp_en && (bus.mem_read || bus.mem_write)) begin
        lat_cnt++;
        if (lat_cnt >= 2) begin
          lat_cnt       = 0;
          bus.mem_rdata = {16{mem_fill}};
          bus.mem_resp  = 1'b1;
        end
      end else lat_cnt = 0;
    end
  end

  task automatic do_store(input logic [AW-1:0] a, input int off, input logic [15:0] d,
                          input logic [1:0] be, input bit fl);
    bit ok = 0;
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_line_addr = a; bus.in_offset = 3'(off);
    bus.in_data = d; bus.in_be = be; bus.flush = fl;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin total++; bad++; $display("FAIL store_timeout: addr %h not accepted", a); end
    @(posedge clk); #1;
    bus.in_valid = 0; bus.flush = 0;
  endtask

  task automatic do_flush();
    @(posedge clk); #1 bus.flush = 1;
    @(posedge clk); #1 bus.flush = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.idle) begin ok = 1; break; end
    end
    if (!ok) begin total++; bad++; $display("FAIL idle_timeout: idle stuck at 0"); end
  endtask

  task automatic check_write(input string name, input logic [AW-1:0] a,
                             input logic [127:0] d, input bit had_read);
    if (wr_data_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: no line write seen, want addr %h", name, a);
    end else begin
      check({name, "_addr"}, wr_addr_q.pop_front(), a);
      check({name, "_data"}, wr_data_q.pop_front(), d);
      check({name, "_read"}, wr_read_q.pop_front(), had_read);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.in_valid = 0; bus.in_line_addr = '0; bus.in_offset = '0;
    bus.in_data = '0; bus.in_be = '0; bus.flush = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check("rst_idle", bus.idle, 1'b1);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);

    // Single store then flush: read-modify-write.
    mem_fill = 8'h11;
    do_store(12'h010, 3, 16'hBEEF, 2'b11, 0);
    do_flush();
    wait_idle();
    check_write("t1", 12'h010, 128'h1111111111111111_BEEF_111111111111, 1);

    // Full line: no read, write starts the cycle after flush.
    mem_fill = 8'hEE;
    for (int o = 0; o < 8; o++) do_store(12'h020, o, 16'h0101 * 16'(o + 1), 2'b11, 0);
    @(posedge clk); #1 bus.flush = 1;
    @(posedge clk); #1 bus.flush = 0;
    @(negedge clk);
    check("t2_write_rise", bus.mem_write, 1'b1);
    check("t2_no_read", bus.mem_read, 1'b0);
    wait_idle();
    check_write("t2", 12'h020, 128'h0808_0707_0606_0505_0404_0303_0202_0101, 0);

    // Overwrites with partial enables.
    mem_fill = 8'h77;
    do_store(12'h040, 0, 16'h00AA, 2'b01, 0);
    do_store(12'h040, 0, 16'h1234, 2'b11, 0);
    do_store(12'h040, 0, 16'h0055, 2'b01, 0);
    do_flush();
    wait_idle();
    check_write("t3", 12'h040, 128'h777777777777777777777777777_71255 >> 0, 1);

    // Miss store stalls until the held line is written back.
    mem_fill = 8'h22;
    do_store(12'h030, 1, 16'h5A5A, 2'b11, 0);
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_line_addr = 12'h031; bus.in_offset = 3'd2;
    bus.in_data = 16'hC3C3; bus.in_be = 2'b10;
    @(negedge clk);
    check("t4_stall", bus.in_ready, 1'b0);
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin total++; bad++; $display("FAIL t4_timeout: miss store never accepted"); end
    check("t4_accept_idle", bus.idle, 1'b1);
    check_write("t4a", 12'h030, 128'h222222222222222222222222_5A5A_2222, 1);
    @(posedge clk); #1 bus.in_valid = 0;
    @(negedge clk);
    check("t4_idle_low", bus.idle, 1'b0);
    do_flush();
    wait_idle();
    check_write("t4b", 12'h031, 128'h22222222222222222222_C3_2222222222, 1);

    // Hit store and flush in the same cycle.
    mem_fill = 8'h00;
    do_store(12'h050, 0, 16'h3344, 2'b11, 0);
    do_store(12'h050, 7, 16'h9900, 2'b10, 1);
    wait_idle();
    check_write("t5", 12'h050, 128'h99_00000000000000000000000000_3344, 1);

    // Reset while a read is outstanding.
    mem_fill = 8'h33;
    resp_en  = 0;
    do_store(12'h060, 0, 16'h00AB, 2'b01, 0);
    do_flush();
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.mem_read) begin ok = 1; break; end
    end
    if (!ok) begin total++; bad++; $display("FAIL t6_timeout: mem_read never rose"); end
    @(posedge clk); #1 reset_n = 0;
    #1;
    check("t6_read_drop", bus.mem_read, 1'b0);
    check("t6_idle", bus.idle, 1'b1);
    #2 reset_n = 1;
    @(posedge clk); #2 bus.mem_resp = 1'b1;
    @(posedge clk); #2 bus.mem_resp = 1'b0;
    resp_en = 1;
    @(negedge clk);
    check("t6_late_resp_idle", bus.idle, 1'b1);
    check("t6_no_write", 128'(wr_data_q.size()), 128'd0);
    do_store(12'h060, 1, 16'hCDEF, 2'b11, 0);
    do_flush();
    wait_idle();
    check_write("t6", 12'h060, 128'h333333333333333333333333_CDEF_3333, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
